mont_mul_cios: RTL and testbench

MONT_MUL_CIOS -- requirements
Module: mont_mul_cios

---
 rtl/mont_mul_cios.sv | 185 ++++++++++++++++++
 tb/tb_mont_mul_cios.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_cios.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^(WORD*NWORDS).
// A single WORD x WORD multiply-accumulate is shared by the MUL, REDM and RED phases.
module mont_mul_cios #(
  parameter int WORD   = 32,
  parameter int NWORDS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WORD*NWORDS-1:0]   a,
  input  logic [WORD*NWORDS-1:0]   b,
  input  logic [WORD*NWORDS-1:0]   n,
  input  logic [WORD-1:0]          n0p,
  output logic [WORD*NWORDS-1:0]   result,
  output logic                     busy,
  output logic                     done
);

  localparam int W  = WORD * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [2:0] {IDLE, MUL, REDM, RED, SUB, DONE} state_e;

  state_e          state_q;
  logic [WORD-1:0] a_q [NWORDS];
  logic [WORD-1:0] b_q [NWORDS];
  logic [WORD-1:0] n_q [NWORDS];
  logic [WORD-1:0] d_q [NWORDS];
  logic [WORD-1:0] t_q [NWORDS];     // T[S-1:0]
  logic [WORD-1:0] t_hi_q;           // T[S]
  logic [WORD-1:0] t_top_q;          // T[S+1]
  logic [WORD-1:0] n0p_q, m_q, c_q;
  logic            borrow_q;
  logic [IW-1:0]   i_q, j_q;
  logic [W-1:0]    result_q;
  logic            busy_q, done_q;

  logic [WORD-1:0]   op_x, op_y, acc_t;
  logic [2*WORD-1:0] mac;
  logic [WORD:0]     top_sum, diff;
  logic              keep_t;
  logic [W-1:0]      sub_res;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    op_x  = m_q;
    op_y  = n_q[j_q];
    acc_t = t_q[j_q];
    case (state_q)
      MUL: begin
        op_x = a_q[j_q];
        op_y = b_q[i_q];
      end
      REDM: begin
        op_x  = t_q[0];
        op_y  = n0p_q;
        acc_t = '0;
      end
      default: ;
    endcase
    // c_q is zero in REDM, so the low word of mac is exactly T[0]*n0p there.
    mac     = (2*WORD)'(op_x) * (2*WORD)'(op_y) + (2*WORD)'(acc_t) + (2*WORD)'(c_q);
    top_sum = {1'b0, t_hi_q} + {1'b0, mac[2*WORD-1:WORD]};
    diff    = {1'b0, t_q[j_q]} - {1'b0, n_q[j_q]} - {{WORD{1'b0}}, borrow_q};
    // T < n exactly when T[S] is clear and the subtraction borrows out.
    keep_t  = (t_hi_q == '0) && diff[WORD];
    sub_res = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (keep_t)
        sub_res[k*WORD +: WORD] = t_q[k];
      else if (k == NWORDS - 1)
        sub_res[k*WORD +: WORD] = diff[WORD-1:0];
      else
        sub_res[k*WORD +: WORD] = d_q[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      n0p_q    <= '0;
      borrow_q <= 1'b0;
      t_hi_q   <= '0;
      t_top_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      // NOTE: these word arrays are flops, not RAM, so clearing them on reset is legal and cheap to reason about.
      for (int k = 0; k < NWORDS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        n_q[k] <= '0;
        d_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NWORDS; k++) begin
              a_q[k] <= a[k*WORD +: WORD];
              b_q[k] <= b[k*WORD +: WORD];
              n_q[k] <= n[k*WORD +: WORD];
              t_q[k] <= '0;
            end
            n0p_q   <= n0p;
            t_hi_q  <= '0;
            t_top_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          t_q[j_q] <= mac[WORD-1:0];
          c_q      <= mac[2*WORD-1:WORD];
          if (j_q == LAST) begin
            t_hi_q  <= top_sum[WORD-1:0];
            t_top_q <= WORD'(top_sum[WORD]);
            c_q     <= '0;
            j_q     <= '0;
            state_q <= REDM;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        REDM: begin
          m_q     <= mac[WORD-1:0];
          state_q <= RED;
        end
        RED: begin
          // Writing word j into slot j-1 performs the divide-by-2^WORD shift.
          if (j_q != '0) t_q[j_q - 1'b1] <= mac[WORD-1:0];
          c_q <= mac[2*WORD-1:WORD];
          if (j_q == LAST) begin
            t_q[NWORDS-1] <= top_sum[WORD-1:0];
            t_hi_q        <= t_top_q + WORD'(top_sum[WORD]);
            c_q           <= '0;
            j_q           <= '0;
            borrow_q      <= 1'b0;
            if (i_q == LAST) begin
              state_q <= SUB;
            end else begin
              i_q     <= i_q + 1'b1;
              state_q <= MUL;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        SUB: begin
          d_q[j_q] <= diff[WORD-1:0];
          borrow_q <= diff[WORD];
          if (j_q == LAST) begin
            result_q <= sub_res;
            done_q   <= 1'b1;
            j_q      <= '0;
            state_q  <= DONE;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mont_mul_cios.sv
// Self-checking bench for mont_mul_cios: directed vector table, abort/restart sequences,
// and back-to-back random runs checked against a bit-serial Montgomery reference model.
module tb_mont_mul_cios;

  localparam int WORD   = 32;
  localparam int NWORDS = 32;
  localparam int W      = WORD * NWORDS;
  localparam int LAT    = NWORDS * (2 * NWORDS + 1) + NWORDS;  // edges from capture to done
  localparam int SPACE  = LAT + 2;                              // done-to-done when start held

  typedef logic [W-1:0] wide_t;
  typedef struct {
    wide_t           a;
    wide_t           b;
    wide_t           n;
    logic [WORD-1:0] n0p;
    wide_t           exp;
    bit              mid_start;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  wide_t           a, b, n;
  logic [WORD-1:0] n0p;
  wide_t           result;
  logic            busy, done;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_count = 0;
  int    cap_cyc = 0;
  logic  busy_prev = 1'b0;
  wide_t sb_q[$];

  vec_t  tbl[5];
  vec_t  bb[3];
  vec_t  va;
  wide_t n_all1, n_p, e22;
  int    dcyc[3];
  int    dc0;

  mont_mul_cios #(.WORD(WORD), .NWORDS(NWORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .n0p    (n0p),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    int k;
    checks++;
    if (act !== exp) begin
      errors++;
      k = 0;
      while (k < NWORDS - 1 && act[k*WORD +: WORD] === exp[k*WORD +: WORD]) k++;
      $display("FAIL %s: word %0d got %h expected %h (t=%0t)",
               name, k, act[k*WORD +: WORD], exp[k*WORD +: WORD], $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, wide_t'(act), wide_t'(exp));
  endtask

  // Radix-2 Montgomery product, independent of the word-serial structure.
  function automatic wide_t mont_ref(input wide_t x, input wide_t y, input wide_t m);
    logic [W+1:0] acc;
    acc = '0;
    for (int k = 0; k < W; k++) begin
      if (x[k]) acc += {2'b00, y};
      if (acc[0]) acc += {2'b00, m};
      acc = acc >> 1;
    end
    if (acc >= {2'b00, m}) acc -= {2'b00, m};
    return acc[W-1:0];
  endfunction

  // -n^-1 mod 2^WORD by Newton iteration.
  function automatic logic [WORD-1:0] n0p_ref(input logic [WORD-1:0] n0);
    logic [WORD-1:0] inv;
    inv = n0;
    for (int k = 0; k < 5; k++) inv = inv * (WORD'(2) - n0 * inv);
    return -inv;
  endfunction

  function automatic wide_t rand_wide();
    wide_t r;
    for (int k = 0; k < NWORDS; k++) r[k*WORD +: WORD] = $urandom;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.n = rand_wide();
    v.n[0] = 1'b1;
    v.n[W-1] = 1'b1;
    v.a = rand_wide();
    v.a[W-1] = 1'b0;
    v.b = rand_wide();
    v.b[W-1] = 1'b0;
    v.n0p = n0p_ref(v.n[WORD-1:0]);
    v.exp = mont_ref(v.a, v.b, v.n);
    v.mid_start = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a = v.a;
    b = v.b;
    n = v.n;
    n0p = v.n0p;
  endtask

  task automatic scramble();
    a = rand_wide();
    b = rand_wide();
    n = rand_wide();
    n0p = $urandom;
  endtask

  task automatic wait_done(input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    if (!seen) check_bit("done_timeout", done, 1'b1);
  endtask

  task automatic wait_busy(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    if (!seen) check_bit("busy_timeout", busy, 1'b1);
  endtask

  task automatic run_op(input vec_t v);
    int at;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    sb_q.push_back(v.exp);
    @(negedge clk);
    start = 1'b0;
    check_bit("busy_after_start", busy, 1'b1);
    scramble();
    if (v.mid_start) begin
      repeat (500) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(LAT + 100, at);
    @(negedge clk);
    check_bit("done_single_pulse", done, 1'b0);
    @(negedge clk);
    check_bit("idle_after_done", busy, 1'b0);
  endtask

  // Scoreboard: every done pops the oldest expected result and checks the capture-to-done latency.
  always @(negedge clk) begin
    wide_t e;
    if (busy && !busy_prev) cap_cyc = cyc;
    busy_prev = busy;
    if (done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check_bit("spurious_done", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e);
        check("latency", wide_t'(cyc - cap_cyc), wide_t'(LAT));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    n = '0;
    n0p = '0;

    n_all1 = '1;
    n_p = '0;
    n_p[W-1] = 1'b1;
    n_p[0] = 1'b1;
    e22 = '0;
    e22[1022] = 1'b1;
    tbl[0] = '{a: wide_t'(1), b: wide_t'(1), n: n_all1, n0p: 32'h1,
               exp: wide_t'(1), mid_start: 1'b0};
    tbl[1] = '{a: n_p - wide_t'(2), b: wide_t'(1), n: n_p, n0p: 32'hFFFF_FFFF,
               exp: wide_t'(1), mid_start: 1'b0};
    tbl[2] = '{a: n_p - wide_t'(1), b: n_p - wide_t'(1), n: n_p, n0p: 32'hFFFF_FFFF,
               exp: e22, mid_start: 1'b0};
    tbl[3] = '{a: wide_t'(0), b: n_p - wide_t'(5), n: n_p, n0p: 32'hFFFF_FFFF,
               exp: wide_t'(0), mid_start: 1'b1};
    // 6 * 2^-1024 mod (2^1023+1) = 6 * 2^1022 = 3 * 2^1023 = -3
    tbl[4] = '{a: wide_t'(2), b: wide_t'(3), n: n_p, n0p: 32'hFFFF_FFFF,
               exp: n_p - wide_t'(3), mid_start: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_result", result, wide_t'(0));
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) run_op(tbl[t]);

    // Abort mid-operation with reset.
    va = rand_vec();
    @(negedge clk);
    drive(va);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (998) @(negedge clk);
    check_bit("busy_before_abort", busy, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check("abort_result", result, wide_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_count;
    repeat (1200) @(negedge clk);
    check("abort_no_done", wide_t'(done_count), wide_t'(dc0));
    check_bit("abort_idle", busy, 1'b0);

    run_op(rand_vec());

    // Back-to-back with start held high; next operands are loaded once the previous capture is done.
    for (int k = 0; k < 3; k++) bb[k] = rand_vec();
    @(negedge clk);
    drive(bb[0]);
    start = 1'b1;
    sb_q.push_back(bb[0].exp);
    @(negedge clk);
    check_bit("b2b_busy", busy, 1'b1);
    drive(bb[1]);
    sb_q.push_back(bb[1].exp);
    wait_done(LAT + 100, dcyc[0]);
    wait_busy(10);
    drive(bb[2]);
    sb_q.push_back(bb[2].exp);
    wait_done(LAT + 100, dcyc[1]);
    wait_busy(10);
    start = 1'b0;
    wait_done(LAT + 100, dcyc[2]);
    check("b2b_spacing_1", wide_t'(dcyc[1] - dcyc[0]), wide_t'(SPACE));
    check("b2b_spacing_2", wide_t'(dcyc[2] - dcyc[1]), wide_t'(SPACE));
    @(negedge clk);
    @(negedge clk);
    check_bit("b2b_stopped", busy, 1'b0);
    check("scoreboard_empty", wide_t'(sb_q.size()), wide_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
